// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator and the sobel edge detector:
// pixel type, window geometry and the (row, column) -> bit-slice mapping of the packed window.
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN      = 5;
  localparam int WIN_BITS = WIN * WIN * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;

  // MSB of tap z(5r+c); use as window[tap_msb(r, c) -: PIX_W]. Row 0 / column 0 are the oldest.
  function automatic int tap_msb(input int r, input int c);
    return WIN_BITS - 1 - PIX_W * (WIN * r + c);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels with a combinational read and a clocked write at the same
// address, so the value read on an accepted pixel is the one stored before that edge.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        din,
  output pixel_t        dout
);

  pixel_t mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 5x5 window generator for the Sobel edge detector.
// Optional feature macro: SOBEL_WINGEN_ZERO_PAD_EN (window on every pixel, out-of-image taps forced to 0).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PIX_W-1:0]    pix_in,
  input  logic                pix_valid,
  input  logic                frame_start,
  output logic [WIN_BITS-1:0] matrix_out,
  output logic                win_valid,
  output logic [XW-1:0]       win_x,
  output logic [YW-1:0]       win_y
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0]       x, cur_x, x_next;
  logic [YW-1:0]       y, cur_y, y_next;
  logic [WIN_BITS-1:0] win_next;
  logic                valid_next;

  // chain[0] is the incoming pixel, chain[i] is line y-i read at the current column.
  pixel_t chain [WIN];

  // frame_start overrides the running position for the pixel being accepted.
  always_comb begin
    cur_x = frame_start ? '0 : x;
    cur_y = frame_start ? '0 : y;
    if (cur_x == X_LAST) begin
      x_next = '0;
      y_next = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
    end else begin
      x_next = cur_x + XW'(1);
      y_next = cur_y;
    end
  end

  assign chain[0] = pix_in;

  for (genvar i = 0; i < WIN - 1; i++) begin : g_lb
    sobel_line_buffer #(
      .DEPTH (H_ACTIVE),
      .AW    (XW)
    ) u_lb (
      .clock (clock),
      .we    (pix_valid),
      .addr  (cur_x),
      .din   (chain[i]),
      .dout  (chain[i+1])
    );
  end

  always_comb begin
    win_next = matrix_out;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win_next[tap_msb(r, c) -: PIX_W] = matrix_out[tap_msb(r, c + 1) -: PIX_W];
      end
      win_next[tap_msb(r, WIN - 1) -: PIX_W] = chain[WIN-1-r];
    end
`ifdef SOBEL_WINGEN_ZERO_PAD_EN
    // Masking the stored window is safe: masked columns only shift towards column 0.
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if ((int'(cur_y) + r < WIN - 1) || (int'(cur_x) + c < WIN - 1)) begin
          win_next[tap_msb(r, c) -: PIX_W] = '0;
        end
      end
    end
    valid_next = 1'b1;
`else
    valid_next = (cur_x >= XW'(WIN - 1)) && (cur_y >= YW'(WIN - 1));
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      matrix_out <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      win_valid <= 1'b0;
      if (pix_valid) begin
        x          <= x_next;
        y          <= y_next;
        matrix_out <= win_next;
        win_valid  <= valid_next;
        win_x      <= cur_x;
        win_y      <= cur_y;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on an 8x8 ramp image (pix = 8y+x).
// Valid/ready: a window is presented when win_valid is high; there is no back-pressure.
module tb_sobel_window_gen;

  localparam int H  = 8;
  localparam int V  = 8;
  localparam int W  = 206;
`ifdef SOBEL_WINGEN_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         frame_start;
  logic [199:0] matrix_out;
  logic         win_valid;
  logic [2:0]   win_x;
  logic [2:0]   win_y;

  // Clock and reset
  always #5 clock = ~clock;

  sobel_window_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .matrix_out  (matrix_out),
    .win_valid   (win_valid),
    .win_x       (win_x),
    .win_y       (win_y)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int win_count = 0;
  int mx = 0;
  int my = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [7:0]   img [V][H];
  logic [7:0]   col3 [5];

  function automatic void check(input string name, input logic [199:0] act, input logic [199:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endfunction

  function automatic logic [7:0] tap(input int k);
    return matrix_out[199-8*k -: 8];
  endfunction

  function automatic logic [7:0] ramp(input bit fs);
    return fs ? 8'h00 : 8'(8 * my + mx);
  endfunction

  // Driver: one accepted pixel; the expected window is built from the bench's image copy.
  task automatic accept(input bit fs, input logic [7:0] p);
    int cx, cy, yy, xx;
    logic [199:0] w;
    cx = fs ? 0 : mx;
    cy = fs ? 0 : my;
    img[cy][cx] = p;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        yy = cy - 4 + r;
        xx = cx - 4 + c;
        w[199-8*(5*r+c) -: 8] = (yy < 0 || xx < 0) ? 8'h00 : img[yy][xx];
      end
    end
    if (ZP || (cx >= 4 && cy >= 4)) exp_q.push_back({3'(cx), 3'(cy), w});
    mx = (cx == H - 1) ? 0 : cx + 1;
    my = (cx == H - 1) ? ((cy == V - 1) ? 0 : cy + 1) : cy;
    pix_in      = p;
    frame_start = fs;
    pix_valid   = 1'b1;
    @(posedge clock);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic ramp_px(input bit fs);
    accept(fs, ramp(fs));
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    @(posedge clock);
    #1;
    check("no_valid_when_idle", 200'(win_valid), 200'(0));
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && win_valid) begin
      win_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_window: x=%0d y=%0d but no window expected", win_x, win_y);
      end else begin
        e = exp_q.pop_front();
        check("win_xy", 200'({win_x, win_y}), 200'(e[205:200]));
        check("win_matrix", matrix_out, e[199:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; pix_in = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_matrix", matrix_out, 200'(0));
    check("reset_valid", 200'(win_valid), 200'(0));
    reset = 1'b0;

    // Mid-frame asynchronous reset
    for (int i = 0; i < 10; i++) ramp_px(i == 0);
    @(posedge clock);
    #6;
    reset = 1'b1;
    #1;
    check("async_rst_matrix", matrix_out, 200'(0));
    check("async_rst_valid", 200'(win_valid), 200'(0));
    check("async_rst_x", 200'(win_x), 200'(0));
    check("async_rst_y", 200'(win_y), 200'(0));
    mx = 0; my = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Frame 1: continuous ramp, directed tap checks and row wrap
    win_count = 0;
    for (int i = 0; i < H * V; i++) begin
      ramp_px(1'b0);
      if (i == 0) begin
        check("post_reset_x", 200'(win_x), 200'(0));
        check("post_reset_y", 200'(win_y), 200'(0));
      end
      if (i / 8 == 5 && i % 8 < 4) check("row_wrap_valid", 200'(win_valid), 200'(ZP));
      if (i == 36) begin
        check("p44_valid", 200'(win_valid), 200'(1));
        check("p44_z0",  200'(tap(0)),  200'(0));
        check("p44_z12", 200'(tap(12)), 200'(18));
        check("p44_z24", 200'(tap(24)), 200'(36));
        check("p44_z4",  200'(tap(4)),  200'(4));
        check("p44_z20", 200'(tap(20)), 200'(32));
      end
      if (i == 44) begin
        check("p45_z0",  200'(tap(0)),  200'(8));
        check("p45_z24", 200'(tap(24)), 200'(44));
      end
    end
    idle();
    check("frame1_windows", 200'(win_count), 200'(ZP ? 64 : 16));

    // Frame 2: random pix_valid gaps
    win_count = 0;
    for (int i = 0; i < H * V; i++) begin
      ramp_px(i == 0);
      repeat ($urandom_range(0, 2)) idle();
    end
    idle();
    check("frame2_windows", 200'(win_count), 200'(ZP ? 64 : 16));

    // Frame 3: frame_start resync at (3,6)
    win_count = 0;
    for (int i = 0; i < 51; i++) ramp_px(i == 0);
    idle();
    check("pre_resync_windows", 200'(win_count), 200'(ZP ? 51 : 8));
    win_count = 0;
    ramp_px(1'b1);
    check("resync_x", 200'(win_x), 200'(0));
    check("resync_y", 200'(win_y), 200'(0));
    check("resync_valid", 200'(win_valid), 200'(ZP));
    for (int i = 1; i < H * V; i++) begin
      ramp_px(1'b0);
      if (i == 36) check("resync_p44_valid", 200'(win_valid), 200'(1));
    end
    idle();
    check("frame3_windows", 200'(win_count), 200'(ZP ? 64 : 16));

`ifdef SOBEL_WINGEN_ZERO_PAD_EN
    // Zero-padded corner windows
    accept(1'b1, 8'h55);
    check("zp_00_valid", 200'(win_valid), 200'(1));
    check("zp_00_matrix", matrix_out, {192'b0, 8'h55});
    for (int i = 1; i <= 33; i++) ramp_px(1'b0);
    col3 = '{8'h55, 8'h08, 8'h10, 8'h18, 8'h20};
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) check("zp_14_pad", 200'(tap(5*r+c)), 200'(0));
      check("zp_14_col3", 200'(tap(5*r+3)), 200'(col3[r]));
    end
`endif

    repeat (3) idle();
    check("queue_empty", 200'(exp_q.size()), 200'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 5x5 window generator that feeds the Sobel edge detector. Accepts one 8-bit grayscale pixel per valid cycle in raster order, keeps the four previous image lines in line buffers, and presents the 200-bit packed window `z0..z24` that the edge detector consumes, with a window-valid strobe and the pixel coordinates. It sits between the camera/frame-buffer read path and the `sobel` instance.

## Interface

**Parameters**
- `H_ACTIVE`, 640: pixels per line; sets the line-buffer depth.
- `V_ACTIVE`, 480: lines per frame.
- `XW`, `$clog2(H_ACTIVE)`: column counter width.
- `YW`, `$clog2(V_ACTIVE)`: row counter width.

**Ports**
- `clock`, input, 1: the single system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `pix_in`, input, 8: incoming pixel.
- `pix_valid`, input, 1: `pix_in` is accepted on this edge.
- `frame_start`, input, 1: qualified by `pix_valid`; the accepted pixel is (0,0).
- `matrix_out`, output, 200: packed window.
  - `z0` is at `[199:192]`; `z24` is at `[7:0]`.
  - `z(5r+c)`: row r (0 = oldest line), column c (0 = oldest pixel).
- `win_valid`, output, 1: `matrix_out` is a complete window.
- `win_x`, output, XW: column of the newest (bottom-right) pixel `z24`.
- `win_y`, output, YW: row of the newest (bottom-right) pixel `z24`.

## Operation

**Counters**
- The column counter `x` and row counter `y` give the position of the pixel being accepted.
- After each accepted pixel, `x` increments.
- At `x = H_ACTIVE-1`, `x` wraps to 0 and `y` increments.
- At (`H_ACTIVE-1`, `V_ACTIVE-1`), both counters wrap to 0.
- When `frame_start` is high with `pix_valid`, the accepted pixel is forced to (0,0), overriding the counters. Counting resumes from (1,0).

**Line buffers**
- There are four line buffers, LB0 to LB3, each `H_ACTIVE` x 8 bits. LB0 holds line y-1 and LB3 holds line y-4.
- On each accepted pixel, read all four buffers at address `x` before writing (read-first).
- Then write `pix_in` to LB0[x], old LB0[x] to LB1[x], old LB1[x] to LB2[x], and old LB2[x] to LB3[x].
- The new column, top to bottom, is {LB3[x], LB2[x], LB1[x], LB0[x], `pix_in`}.

**Window register**
- A 5x5 register shifts left by one column per accepted pixel. The new column enters at c=4.
- `matrix_out` is driven directly from this register.

**Outputs**
- `win_valid` is 1 for an accepted pixel with x ≥ 4 and y ≥ 4. It is 0 otherwise, and 0 on any edge with no accepted pixel.
- `win_x`/`win_y` register the accepted pixel's coordinates on the same edge as the window.

**Hold behaviour**
- When `pix_valid` is 0, counters, buffers and the window hold.
- `matrix_out`, `win_x` and `win_y` keep their last values.

**Reset**
- `matrix_out`, `win_valid`, `win_x`, `win_y`, `x` and `y` all reset to 0.
- Line-buffer contents are not reset. This is safe because `win_valid` gating or zero-pad masking hides stale data.
- A reset mid-frame makes the next accepted pixel (0,0).

## Timing

- Latency: 1 cycle. A pixel accepted on edge N appears as `z24` on the outputs after edge N. `win_valid` is high for exactly that cycle.
- Throughput: one pixel per clock, with no back-pressure.
- The first valid window of a frame follows the pixel at (4,4).
- Per frame, with the macro off, `(H_ACTIVE-4)*(V_ACTIVE-4)` valid windows are produced.
- At a row wrap, the window register holds stale columns from the previous line. Windows at x = 0..3 are invalid.

## Configuration

**`SOBEL_WINGEN_ZERO_PAD_EN`**
- Defined:
  - `win_valid` asserts for every accepted pixel.
  - A tap is forced to 0 when its row r satisfies y-(4-r) < 0, or its column c satisfies x-(4-c) < 0.
  - This gives `H_ACTIVE*V_ACTIVE` windows per frame.
- Undefined:
  - The gating above applies, with no masking logic.
  - The output register contents are identical for windows with x ≥ 4 and y ≥ 4.

## Structure

**Shared package `sobel_pkg`**
- `PIX_W` = 8, `WIN` = 5, `WIN_BITS` = 200.
- A `pixel_t` typedef.
- A tap-slice function mapping (r, c) to bit range `[199-8(5r+c) -: 8]`, shared with `sobel`.

**Sub-module `sobel_line_buffer`**
- One line of `H_ACTIVE` x 8 with a read-first write port.
- Instantiated four times and chained.

## Test plan

1. **Reset.** Assert `reset` asynchronously mid-frame. Required: all outputs 0 immediately, and the next accepted pixel reports `win_x`=0, `win_y`=0.
2. **Ramp image.** Set `H_ACTIVE`=8, `V_ACTIVE`=8, and drive pix = 8y+x continuously. At (4,4), required: `win_valid`=1, z0=0, z12=18, z24=36, z4=4, z20=32. There are 16 valid windows per frame.
3. **Random `pix_valid` gaps.** Use the same image as scenario 2. Required: the identical window sequence, and `win_valid` only on the cycle after an accepted pixel.
4. **Row wrap.** Use the same image as scenario 2. Required: pixels (0..3,5) give `win_valid`=0. Pixel (4,5) gives z0=8, z24=44.
5. **`frame_start` resync.** Pulse `frame_start` at (3,6). Required: that pixel reports (0,0), and no `win_valid` occurs until the new (4,4).
6. **Zero pad, macro defined.** At (0,0) with pix=0x55, required: `win_valid`=1 and `matrix_out` = {192'b0, 8'h55}. At (1,4), required: columns 0 to 2 are 0 and column 3 holds pixels (0,0..4).
